// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle RV32I control sequencer. Each instruction walks through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and the datapath selects are
//   decoded combinationally from the registered state and the instruction.
//   A wait counter guards every memory request; a request that waits too
//   long, or an illegal instruction (when trapping is enabled), parks the
//   controller in TRAP until reset.
//
//   Ports
//     clk, rst_n         clock (rising edge), async active-low reset
//     inst               instruction register contents
//     BrEq, BrLt         branch comparator results
//     mem_ready          memory completes the current request this cycle
//     IRWen, PCWen       IR / PC write enables
//     PCsel              0 = PC+4, 1 = ALU result
//     RegWen             register-file write
//     BrUn               unsigned branch compare
//     Asel, Bsel         ALU operand selects (rs1/PC, rs2/imm)
//     MemReq, MemRW      memory request, 0 = read / 1 = write
//     imm_sel            0 I, 1 S, 2 B, 3 U, 4 J, 5 none
//     Alu_sel            ALU operation
//     WBsel              0 mem, 1 ALU, 2 PC+4
//     mem_size           0 byte, 1 half, 2 word
//     mem_unsigned       zero-extend load data
//     illegal, timeout   sticky trap-cause flags
//     state              current FSM state
//
//   state  | meaning
//   IDLE   | one settling cycle after reset release
//   FETCH  | read instruction, load IR on mem_ready
//   DECODE | validate instruction, trap or skip illegal ones
//   EXEC   | ALU operation; branches resolve and finish here
//   MEM    | load/store access
//   WB     | register write-back and PC update
//   TRAP   | all strobes off until reset

module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT     = 16,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        BrEq,
    input  logic        BrLt,
    input  logic        mem_ready,
    output logic        IRWen,
    output logic        PCWen,
    output logic        PCsel,
    output logic        RegWen,
    output logic        BrUn,
    output logic        Asel,
    output logic        Bsel,
    output logic        MemReq,
    output logic        MemRW,
    output logic [2:0]  imm_sel,
    output logic [3:0]  Alu_sel,
    output logic [1:0]  WBsel,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                           ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                           ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                           ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    // Count of wait cycles already spent; the cycle that would make it
    // MEM_TIMEOUT traps unless mem_ready arrives in that same cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_load, is_store, is_branch, is_jump;
    logic       inst_illegal, br_taken;
    logic [3:0] dec_alu;
    logic       dec_asel, dec_bsel;
    logic [2:0] dec_imm;
    logic       unused_inst;

    assign opcode      = inst[6:2];
    assign funct3      = inst[14:12];
    assign funct7      = inst[31:25];
    assign unused_inst = ^{inst[24:15], inst[11:7], inst[1:0]};

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        inst_illegal = 1'b0;
        case (opcode)
            OPC_OP:     inst_illegal = !((funct7 == 7'h00) ||
                                         ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            OPC_OPIMM:  inst_illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                                       ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
            OPC_LOAD:   inst_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OPC_STORE:  inst_illegal = (funct3 >= 3'b011);
            OPC_BRANCH: inst_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OPC_JALR:   inst_illegal = (funct3 != 3'b000);
            OPC_LUI, OPC_AUIPC, OPC_JAL: inst_illegal = 1'b0;
            default:    inst_illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_alu  = ALU_ADD;
        dec_asel = 1'b0;
        dec_bsel = 1'b1;
        dec_imm  = 3'd0;
        case (opcode)
            OPC_OP: begin
                dec_alu  = alu_from_f3(funct3, inst[30]);
                dec_bsel = 1'b0;
                dec_imm  = 3'd5;
            end
            // ADDI's immediate may set bit 30; only the shifts use it as a selector.
            OPC_OPIMM:  dec_alu  = alu_from_f3(funct3, inst[30] && (funct3 == 3'b101));
            OPC_STORE:  dec_imm  = 3'd1;
            OPC_BRANCH: begin dec_asel = 1'b1; dec_imm = 3'd2; end
            OPC_JAL:    begin dec_asel = 1'b1; dec_imm = 3'd4; end
            OPC_LUI:    begin dec_alu  = ALU_PASSB; dec_imm = 3'd3; end
            OPC_AUIPC:  begin dec_asel = 1'b1; dec_imm = 3'd3; end
            default:    ;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:        br_taken = BrEq;
            3'b001:        br_taken = !BrEq;
            3'b100, 3'b110: br_taken = BrLt;
            3'b101, 3'b111: br_taken = !BrLt;
            default:       br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = 8'd0;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        IRWen        = 1'b0;
        PCWen        = 1'b0;
        PCsel        = 1'b0;
        RegWen       = 1'b0;
        BrUn         = 1'b0;
        Asel         = 1'b0;
        Bsel         = 1'b0;
        MemReq       = 1'b0;
        MemRW        = 1'b0;
        imm_sel      = 3'd5;
        Alu_sel      = ALU_ADD;
        WBsel        = 2'd0;
        mem_size     = 2'd0;
        mem_unsigned = 1'b0;

        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            Alu_sel = dec_alu;
            Asel    = dec_asel;
            Bsel    = dec_bsel;
            imm_sel = dec_imm;
        end

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemReq   = 1'b1;
                mem_size = 2'd2;
                if (mem_ready) begin
                    IRWen   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (!inst_illegal) begin
                    state_d = S_EXEC;
                end else if (TRAP_ON_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    PCWen   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    BrUn    = funct3[1];
                    PCWen   = 1'b1;
                    PCsel   = br_taken;
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                MemReq       = 1'b1;
                MemRW        = is_store;
                mem_size     = funct3[1:0];
                mem_unsigned = funct3[2];
                if (mem_ready) begin
                    if (is_store) begin
                        PCWen   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                RegWen  = 1'b1;
                PCWen   = 1'b1;
                WBsel   = is_load ? 2'd0 : (is_jump ? 2'd2 : 2'd1);
                PCsel   = is_jump;
                state_d = S_FETCH;
            end
            S_TRAP:  ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0] st;
        logic       irw, pcw, pcs, rw, bru, asel, bsel, mreq, mrw;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [1:0] wbs, msz;
        logic       muns, ill, to;
    } ctl_t;

    localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;
    localparam logic [6:0] JAL = 7'h6F, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;

    // ALU code for R-type indexed by {inst[30], funct3}; 15 marks unused slots
    int R_ALU [16] = '{0, 2, 3, 4, 5, 6, 8, 9, 1, 15, 15, 15, 15, 7, 15, 15};
    int LD_F3 [5]  = '{0, 1, 2, 4, 5};
    int BR_F3 [6]  = '{0, 1, 4, 5, 6, 7};
    logic [31:0] ILL [9] = '{32'h0000007F,
                             {7'h20, 5'd2, 5'd1, 3'b001, 5'd3, OP},
                             {7'h01, 5'd2, 5'd1, 3'b000, 5'd3, OP},
                             {7'h20, 5'd3, 5'd1, 3'b001, 5'd3, OPI},
                             {12'h0, 5'd1, 3'b011, 5'd3, LD},
                             {7'h0, 5'd2, 5'd1, 3'b011, 5'd4, ST},
                             {7'h0, 5'd2, 5'd1, 3'b010, 5'd4, BR},
                             {12'h0, 5'd1, 3'b001, 5'd3, JALR},
                             {25'h0, 7'h0B}};

    logic clk = 1'b0, rst_n = 1'b1;
    logic [31:0] inst = 32'h0;
    logic BrEq = 1'b0, BrLt = 1'b0, mem_ready = 1'b0;
    int tests = 0, fails = 0;

    logic IRWen_a, PCWen_a, PCsel_a, RegWen_a, BrUn_a, Asel_a, Bsel_a, MemReq_a, MemRW_a;
    logic [2:0] imm_sel_a, state_a; logic [3:0] Alu_sel_a; logic [1:0] WBsel_a, mem_size_a;
    logic mem_unsigned_a, illegal_a, timeout_a;
    logic IRWen_b, PCWen_b, PCsel_b, RegWen_b, BrUn_b, Asel_b, Bsel_b, MemReq_b, MemRW_b;
    logic [2:0] imm_sel_b, state_b; logic [3:0] Alu_sel_b; logic [1:0] WBsel_b, mem_size_b;
    logic mem_unsigned_b, illegal_b, timeout_b;

    // a: traps on illegal, short timeout; b: illegal as NOP, default timeout
    multicycle_controller #(.MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .inst(inst), .BrEq(BrEq), .BrLt(BrLt), .mem_ready(mem_ready),
        .IRWen(IRWen_a), .PCWen(PCWen_a), .PCsel(PCsel_a), .RegWen(RegWen_a), .BrUn(BrUn_a),
        .Asel(Asel_a), .Bsel(Bsel_a), .MemReq(MemReq_a), .MemRW(MemRW_a), .imm_sel(imm_sel_a),
        .Alu_sel(Alu_sel_a), .WBsel(WBsel_a), .mem_size(mem_size_a), .mem_unsigned(mem_unsigned_a),
        .illegal(illegal_a), .timeout(timeout_a), .state(state_a));

    multicycle_controller #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .inst(inst), .BrEq(BrEq), .BrLt(BrLt), .mem_ready(mem_ready),
        .IRWen(IRWen_b), .PCWen(PCWen_b), .PCsel(PCsel_b), .RegWen(RegWen_b), .BrUn(BrUn_b),
        .Asel(Asel_b), .Bsel(Bsel_b), .MemReq(MemReq_b), .MemRW(MemRW_b), .imm_sel(imm_sel_b),
        .Alu_sel(Alu_sel_b), .WBsel(WBsel_b), .mem_size(mem_size_b), .mem_unsigned(mem_unsigned_b),
        .illegal(illegal_b), .timeout(timeout_b), .state(state_b));

    ctl_t obs_a, obs_b;
    assign obs_a = {state_a, IRWen_a, PCWen_a, PCsel_a, RegWen_a, BrUn_a, Asel_a, Bsel_a, MemReq_a,
                    MemRW_a, imm_sel_a, Alu_sel_a, WBsel_a, mem_size_a, mem_unsigned_a, illegal_a, timeout_a};
    assign obs_b = {state_b, IRWen_b, PCWen_b, PCsel_b, RegWen_b, BrUn_b, Asel_b, Bsel_b, MemReq_b,
                    MemRW_b, imm_sel_b, Alu_sel_b, WBsel_b, mem_size_b, mem_unsigned_b, illegal_b, timeout_b};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic ctl_t base(input logic [2:0] st);
        ctl_t c;
        c = '0;
        c.st = st;
        c.imm = 3'd5;
        return c;
    endfunction

    function automatic ctl_t fetch_v(input logic irw);
        ctl_t c;
        c = base(3'd1);
        c.mreq = 1'b1;
        c.msz = 2'd2;
        c.irw = irw;
        return c;
    endfunction

    function automatic ctl_t with_alu(input ctl_t c0, input logic [31:0] ins);
        ctl_t c;
        logic [2:0] f3;
        c = c0;
        f3 = ins[14:12];
        case (ins[6:0])
            OP:    c.alu = 4'(R_ALU[{ins[30], f3}]);
            OPI:   begin c.alu = 4'(R_ALU[(f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3}]); c.bsel = 1; c.imm = 0; end
            LD:    begin c.bsel = 1; c.imm = 0; end
            ST:    begin c.bsel = 1; c.imm = 1; end
            BR:    begin c.asel = 1; c.bsel = 1; c.imm = 2; end
            JAL:   begin c.asel = 1; c.bsel = 1; c.imm = 4; end
            JALR:  begin c.bsel = 1; c.imm = 0; end
            LUI:   begin c.alu = 4'd10; c.bsel = 1; c.imm = 3; end
            AUIPC: begin c.asel = 1; c.bsel = 1; c.imm = 3; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] gen(input int cls);
        logic [31:0] r, res;
        logic [2:0] f3;
        logic [6:0] up;
        r = $urandom;
        f3 = r[14:12];
        up = r[31:25];
        case (cls)
            0: begin
                up = ((f3 == 3'd0 || f3 == 3'd5) && r[30]) ? 7'h20 : 7'h00;
                res = {up, r[24:15], f3, r[11:7], OP};
            end
            1: begin
                if (f3 == 3'd1) up = 7'h00;
                else if (f3 == 3'd5) up = r[30] ? 7'h20 : 7'h00;
                res = {up, r[24:15], f3, r[11:7], OPI};
            end
            2: begin f3 = 3'(LD_F3[$urandom_range(0, 4)]); res = {r[31:15], f3, r[11:7], LD}; end
            3: begin f3 = 3'($urandom_range(0, 2)); res = {r[31:15], f3, r[11:7], ST}; end
            4: begin f3 = 3'(BR_F3[$urandom_range(0, 5)]); res = {r[31:15], f3, r[11:7], BR}; end
            5: res = {r[31:7], JAL};
            6: res = {r[31:15], 3'b000, r[11:7], JALR};
            7: res = {r[31:7], LUI};
            default: res = {r[31:7], AUIPC};
        endcase
        return res;
    endfunction

    task automatic check(input ctl_t ea, input ctl_t eb, input string tag);
        tests += 2;
        assert (obs_a === ea) else begin
            fails++;
            $error("FAIL %s inst=%h dut_a observed=%h expected=%h", tag, inst, obs_a, ea);
        end
        assert (obs_b === eb) else begin
            fails++;
            $error("FAIL %s inst=%h dut_b observed=%h expected=%h", tag, inst, obs_b, eb);
        end
    endtask

    task automatic step(input ctl_t ea, input ctl_t eb, input string tag);
        @(negedge clk);
        check(ea, eb, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input ctl_t e, input string tag);
        step(e, e, tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check(base(3'd0), base(3'd0), "reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step1(base(3'd0), "idle");
    endtask

    // Walks one instruction from FETCH through its last state, checking every cycle
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic beq, input logic blt);
        ctl_t e;
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        for (int i = 0; i < fw; i++) begin
            mem_ready = 1'b0;
            step1(fetch_v(1'b0), "fetch_wait");
        end
        mem_ready = 1'b1;
        step1(fetch_v(1'b1), "fetch_ready");
        inst = ins; BrEq = beq; BrLt = blt; mem_ready = 1'($urandom);
        step1(base(3'd2), "decode");
        e = with_alu(base(3'd3), ins);
        if (op == BR) begin
            e.bru = f3[1];
            e.pcw = 1'b1;
            e.pcs = (f3[2] ? blt : beq) ^ f3[0];
            step1(e, "exec_branch");
            return;
        end
        step1(e, "exec");
        if (op == LD || op == ST) begin
            e = with_alu(base(3'd4), ins);
            e.mreq = 1'b1; e.mrw = (op == ST); e.msz = f3[1:0]; e.muns = f3[2];
            for (int i = 0; i < mw; i++) begin
                mem_ready = 1'b0;
                step1(e, "mem_wait");
            end
            mem_ready = 1'b1;
            e.pcw = (op == ST);
            step1(e, "mem_ready");
            if (op == ST) return;
            mem_ready = 1'($urandom);
        end
        e = with_alu(base(3'd5), ins);
        e.rw = 1'b1; e.pcw = 1'b1;
        e.wbs = (op == LD) ? 2'd0 : ((op == JAL || op == JALR) ? 2'd2 : 2'd1);
        e.pcs = (op == JAL || op == JALR);
        step1(e, "wb");
    endtask

    initial begin
        ctl_t ea, eb, em;
        logic [31:0] lw;
        #3;
        do_reset();
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);                           // ADD x3,x1,x2
        run_instr({12'h0, 5'd1, 3'b100, 5'd5, LD}, 1, 2, 1'b0, 1'b0);         // LBU
        run_instr({7'h0, 5'd2, 5'd1, 3'b001, 5'd8, BR}, 0, 0, 1'b0, 1'b0);    // BNE taken
        run_instr({7'h0, 5'd2, 5'd1, 3'b001, 5'd8, BR}, 0, 0, 1'b1, 1'b0);    // BNE not taken
        run_instr({7'h0, 5'd2, 5'd1, 3'b111, 5'd8, BR}, 0, 0, 1'b0, 1'b1);    // BGEU
        run_instr({7'h0, 5'd2, 5'd1, 3'b010, 5'd4, ST}, 3, 3, 1'b0, 1'b0);    // SW, waits at limit-1
        for (int n = 0; n < 70; n++)
            run_instr(gen($urandom_range(0, 8)), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom));

        // asynchronous reset in the middle of an instruction
        mem_ready = 1'b1;
        step1(fetch_v(1'b1), "mid_fetch");
        inst = 32'h002081B3;
        step1(base(3'd2), "mid_decode");
        #2 rst_n = 1'b0;
        #1 check(base(3'd0), base(3'd0), "async_reset");
        do_reset();

        for (int k = 0; k < 9; k++) begin
            mem_ready = 1'b1;
            step1(fetch_v(1'b1), "ill_fetch");
            inst = ILL[k]; mem_ready = 1'b0;
            ea = base(3'd2); eb = base(3'd2); eb.pcw = 1'b1;
            step(ea, eb, "ill_decode");
            ea = base(3'd6); ea.ill = 1'b1;
            step(ea, fetch_v(1'b0), "ill_next");
            step(ea, fetch_v(1'b0), "ill_hold");
            do_reset();
        end

        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step1(fetch_v(1'b0), "fto_wait");
        ea = base(3'd6); ea.to = 1'b1;
        step(ea, fetch_v(1'b0), "fto_trap");
        mem_ready = 1'b1;
        step(ea, fetch_v(1'b1), "fto_hold");
        do_reset();

        lw = {12'h010, 5'd1, 3'b010, 5'd6, LD};
        mem_ready = 1'b1;
        step1(fetch_v(1'b1), "mto_fetch");
        inst = lw;
        step1(base(3'd2), "mto_decode");
        step1(with_alu(base(3'd3), lw), "mto_exec");
        em = with_alu(base(3'd4), lw); em.mreq = 1'b1; em.msz = 2'd2;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step1(em, "mto_wait");
        ea = base(3'd6); ea.to = 1'b1;
        step(ea, em, "mto_trap");
        do_reset();

        run_instr({20'hABCDE, 5'd7, JAL}, 0, 0, 1'b0, 1'b0);
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
